// File: rtl/pkt_fifo_sched.sv
// Two-port packet scheduler: round-robin grant, wait for a firewall verdict
// (fail-closed timeout), then forward or drop one packet. Stats outputs under FIFO_SCHED_STATS_EN.
module pkt_fifo_sched #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pkt_rdy,
    input  logic [1:0] rd_eop,
    input  logic       dec_valid,
    input  logic       dec_drop,
    input  logic       out_ready,
    output logic [1:0] fifo_rd,
    output logic [1:0] grant,
    output logic       insp_start,
    output logic       out_valid,
    output logic       busy
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [15:0] fwd_cnt,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_DEC, XFER} state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_flag_q, drop_flag_d;
    logic             insp_q, insp_d;
    logic             busy_q, busy_d;
    logic             sel, pop, done;

    // grant_q is one-hot while busy, so bit 1 doubles as the port index
    assign sel       = grant_q[1];
    assign pop       = (state_q == XFER) && (drop_flag_q || out_ready);
    assign done      = pop && rd_eop[sel];
    assign fifo_rd   = pop ? grant_q : 2'b00;
    assign out_valid = (state_q == XFER) && !drop_flag_q && out_ready;

    assign grant      = grant_q;
    assign insp_start = insp_q;
    assign busy       = busy_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        drop_flag_d = drop_flag_q;
        case (state_q)
            IDLE: begin
                if (|pkt_rdy) begin
                    state_d = GRANT;
                    if (&pkt_rdy) grant_d = last_q ? 2'b01 : 2'b10;
                    else          grant_d = pkt_rdy;
                end
            end
            GRANT: begin
                cnt_d       = '0;
                drop_flag_d = 1'b0;
                state_d     = WAIT_DEC;
            end
            WAIT_DEC: begin
                // a verdict landing on the timeout cycle still wins
                if (dec_valid) begin
                    drop_flag_d = dec_drop;
                    state_d     = XFER;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    drop_flag_d = 1'b1;
                    state_d     = XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = sel;
                end
            end
            default: state_d = IDLE;
        endcase
        insp_d = (state_d == GRANT);
        busy_d = (state_d != IDLE);
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [15:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

    assign fwd_cnt  = fwd_cnt_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (done) begin
            if (drop_flag_q && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            if (!drop_flag_q && fwd_cnt_q != 16'hFFFF) fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            drop_flag_q <= 1'b0;
            insp_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            drop_flag_q <= drop_flag_d;
            insp_q      <= insp_d;
            busy_q      <= busy_d;
        end
    end

endmodule
